// File: rtl/timetodig_pkg.sv
// timetodig_pkg: shared types and constants for the pattern-stream decoder.
//   state_t  - alignment FSM states (HUNT, SYNC, LOCKED)
//   idx_t    - 3-bit symbol index 0..4
//   SYM0..4  - one-hot-style symbol codes, BAD_CODE flags a known illegal code
//   next_idx - expected-index advance with wrap 4->0
package timetodig_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  typedef logic [2:0] idx_t;

  localparam logic [3:0] SYM0     = 4'b0000;
  localparam logic [3:0] SYM1     = 4'b0001;
  localparam logic [3:0] SYM2     = 4'b0010;
  localparam logic [3:0] SYM3     = 4'b0100;
  localparam logic [3:0] SYM4     = 4'b1000;
  localparam logic [3:0] BAD_CODE = 4'b0110;

  localparam idx_t NUM_SYM  = 3'd5;
  localparam idx_t LAST_IDX = 3'd4;

  // Advance the expected symbol index, wrapping after the last symbol.
  function automatic idx_t next_idx(input idx_t i);
    return (i == LAST_IDX) ? 3'd0 : (i + 3'd1);
  endfunction

endpackage

// File: rtl/timetodig_symdec.sv
// timetodig_symdec: combinational decode of one 4-bit pattern code.
// Ports:
//   code   in  [3:0]  registered pattern code
//   valid  out        code is one of the five legal symbols
//   index  out [2:0]  symbol index 0..4 (0 when not valid)
//   is_bad out        code equals the dedicated bad code 0110
module timetodig_symdec
  import timetodig_pkg::*;
(
  input  logic [3:0] code,
  output logic       valid,
  output idx_t       index,
  output logic       is_bad
);

  // Map legal codes to their index; everything else is invalid.
  always_comb begin
    valid  = 1'b1;
    index  = 3'd0;
    is_bad = 1'b0;
    case (code)
      SYM0:     index = 3'd0;
      SYM1:     index = 3'd1;
      SYM2:     index = 3'd2;
      SYM3:     index = 3'd3;
      SYM4:     index = 3'd4;
      BAD_CODE: begin
        valid  = 1'b0;
        is_bad = 1'b1;
      end
      default:  valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/timetodig.sv
// timetodig: receive-side decoder / alignment recovery for the repeating
// 0000,0001,0010,0100,1000 pattern stream.
// Ports:
//   clk         in           rising-edge clock
//   rst         in           synchronous reset, active low
//   d_in        in  [3:0]    incoming pattern
//   count_out   out [2:0]    recovered symbol index, held when not valid
//   count_valid out          symbol matched the flywheel (LOCKED only)
//   frame_done  out          pulse when symbol 4 matches in LOCKED
//   locked      out          FSM is in LOCKED
//   err_pulse   out          pulse on any mismatch in LOCKED
//   bad_code    out          pulse when the registered input is 0110
//   err_count   out [ERR_W]  saturating count of err_pulse events
// d_in is registered first; all decisions use that copy, so outputs lag
// d_in by two edges.
module timetodig
  import timetodig_pkg::*;
#(
  parameter int LOCK_FRAMES = 2,
  parameter int MISS_MAX    = 3,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       d_in,
  output logic [2:0]       count_out,
  output logic             count_valid,
  output logic             frame_done,
  output logic             locked,
  output logic             err_pulse,
  output logic             bad_code,
  output logic [ERR_W-1:0] err_count
);

  localparam int FW = $clog2(LOCK_FRAMES + 1);
  localparam int MW = $clog2(MISS_MAX + 1);

  logic [3:0]       d_q_r;
  state_t           state_r, state_s;
  idx_t             exp_r, exp_s;
  logic [FW-1:0]    frames_r, frames_s;
  logic [MW-1:0]    miss_r, miss_s;
  idx_t             count_r, count_s;
  logic             cv_r, cv_s, fd_r, fd_s, ep_r, ep_s, bc_r, bc_s, lk_r;
  logic [ERR_W-1:0] errc_r, errc_s;
  logic             sym_valid_s, sym_bad_s, match_s;
  idx_t             sym_idx_s;

  timetodig_symdec u_symdec (
    .code   (d_q_r),
    .valid  (sym_valid_s),
    .index  (sym_idx_s),
    .is_bad (sym_bad_s)
  );

  assign count_out   = count_r;
  assign count_valid = cv_r;
  assign frame_done  = fd_r;
  assign locked      = lk_r;
  assign err_pulse   = ep_r;
  assign bad_code    = bc_r;
  assign err_count   = errc_r;

  // Next-state and next-output logic for the alignment FSM.
  always_comb begin
    state_s  = state_r;
    exp_s    = exp_r;
    frames_s = frames_r;
    miss_s   = miss_r;
    count_s  = count_r;
    cv_s     = 1'b0;
    fd_s     = 1'b0;
    ep_s     = 1'b0;
    bc_s     = sym_bad_s;
    errc_s   = errc_r;
    match_s  = sym_valid_s && (sym_idx_s == exp_r);
    case (state_r)
      HUNT: begin
        if (sym_valid_s && (sym_idx_s == 3'd0)) begin
          state_s  = SYNC;
          exp_s    = 3'd1;
          frames_s = {FW{1'b0}};
        end else begin
          state_s  = HUNT;
        end
      end
      SYNC: begin
        if (match_s) begin
          exp_s = next_idx(exp_r);
          if (exp_r == LAST_IDX) begin
            // Completing the last required frame: exp wraps to 0 naturally.
            if (frames_r == FW'(LOCK_FRAMES - 1)) begin
              state_s  = LOCKED;
              frames_s = {FW{1'b0}};
              miss_s   = {MW{1'b0}};
            end else begin
              frames_s = frames_r + {{(FW-1){1'b0}}, 1'b1};
            end
          end else begin
            frames_s = frames_r;
          end
        end else if (sym_valid_s && (sym_idx_s == 3'd0)) begin
          // Repeated 0000 (e.g. generator held in reset): restart the frame.
          exp_s    = 3'd1;
          frames_s = {FW{1'b0}};
        end else begin
          state_s  = HUNT;
        end
      end
      LOCKED: begin
        // The flywheel advances on every symbol, matched or not.
        exp_s = next_idx(exp_r);
        if (match_s) begin
          count_s = sym_idx_s;
          cv_s    = 1'b1;
          fd_s    = (sym_idx_s == LAST_IDX);
          miss_s  = {MW{1'b0}};
        end else begin
          ep_s = 1'b1;
          if (errc_r == {ERR_W{1'b1}}) begin
            errc_s = errc_r;
          end else begin
            errc_s = errc_r + {{(ERR_W-1){1'b0}}, 1'b1};
          end
          if (miss_r == MW'(MISS_MAX - 1)) begin
            state_s = HUNT;
            miss_s  = {MW{1'b0}};
          end else begin
            miss_s  = miss_r + {{(MW-1){1'b0}}, 1'b1};
          end
        end
      end
      default: state_s = HUNT;
    endcase
  end

  // State, counters, input register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      d_q_r    <= 4'b0000;
      state_r  <= HUNT;
      exp_r    <= 3'd0;
      frames_r <= {FW{1'b0}};
      miss_r   <= {MW{1'b0}};
      count_r  <= 3'd0;
      cv_r     <= 1'b0;
      fd_r     <= 1'b0;
      ep_r     <= 1'b0;
      bc_r     <= 1'b0;
      lk_r     <= 1'b0;
      errc_r   <= {ERR_W{1'b0}};
    end else begin
      d_q_r    <= d_in;
      state_r  <= state_s;
      exp_r    <= exp_s;
      frames_r <= frames_s;
      miss_r   <= miss_s;
      count_r  <= count_s;
      cv_r     <= cv_s;
      fd_r     <= fd_s;
      ep_r     <= ep_s;
      bc_r     <= bc_s;
      lk_r     <= (state_s == LOCKED);
      errc_r   <= errc_s;
    end
  end

endmodule

// File: tb/tb_timetodig.sv
module tb_timetodig;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d_in, d_sat;
  logic [2:0] count_out;
  logic       count_valid, frame_done, locked, err_pulse, bad_code;
  logic [7:0] err_count;

  logic [2:0] sat_count_out;
  logic       sat_cv, sat_fd, sat_locked, sat_ep, sat_bc;
  logic [1:0] sat_err_count;

  typedef struct packed {
    logic       cv;
    logic [2:0] cnt;
    logic       fd;
    logic       ep;
    logic       bc;
    logic [7:0] ec;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  n_vec = 0;
  int  n_err = 0;

  always #5 clk = ~clk;

  timetodig dut (
    .clk(clk), .rst(rst), .d_in(d_in),
    .count_out(count_out), .count_valid(count_valid), .frame_done(frame_done),
    .locked(locked), .err_pulse(err_pulse), .bad_code(bad_code),
    .err_count(err_count)
  );

  timetodig #(.LOCK_FRAMES(2), .MISS_MAX(8), .ERR_W(2)) u_sat (
    .clk(clk), .rst(rst), .d_in(d_sat),
    .count_out(sat_count_out), .count_valid(sat_cv), .frame_done(sat_fd),
    .locked(sat_locked), .err_pulse(sat_ep), .bad_code(sat_bc),
    .err_count(sat_err_count)
  );

  function automatic logic [3:0] code_of(input int i);
    case (i)
      0: return 4'b0000;
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b0100;
      4: return 4'b1000;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic step(input logic [3:0] d);
    d_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step_sat(input logic [3:0] d);
    d_sat = d;
    @(posedge clk);
    #1;
  endtask

  // Present a symbol whose processing must produce the given output event.
  task automatic sym(input logic [3:0] d, input logic cv, input logic [2:0] cnt,
                     input logic fd, input logic ep, input logic bc, input logic [7:0] ec);
    ev_t e;
    e.cv = cv; e.cnt = cnt; e.fd = fd; e.ep = ep; e.bc = bc; e.ec = ec;
    exp_q.push_back(e);
    step(d);
  endtask

  task automatic quiet_frame();
    for (int i = 0; i < 5; i++) step(code_of(i));
  endtask

  // Clean frame while locked: every symbol matches.
  task automatic lframe(input logic [7:0] ec);
    for (int i = 0; i < 5; i++) begin
      sym(code_of(i), 1'b1, 3'(i), (i == 4), 1'b0, 1'b0, ec);
      if (i == 0) check("locked_in_frame", {31'd0, locked}, 32'd1);
    end
  endtask

  // Scoreboard monitor: every output event pops one expected record.
  always @(negedge clk) begin
    if (count_valid || err_pulse || bad_code) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: cv=%0d cnt=%0d fd=%0d ep=%0d bc=%0d ec=%0d, expected none",
                 count_valid, count_out, frame_done, err_pulse, bad_code, err_count);
      end else begin
        mon_e = exp_q.pop_front();
        if ({count_valid, count_out, frame_done, err_pulse, bad_code, err_count} !== mon_e) begin
          n_err++;
          $display("FAIL event: got cv=%0d cnt=%0d fd=%0d ep=%0d bc=%0d ec=%0d, expected cv=%0d cnt=%0d fd=%0d ep=%0d bc=%0d ec=%0d",
                   count_valid, count_out, frame_done, err_pulse, bad_code, err_count,
                   mon_e.cv, mon_e.cnt, mon_e.fd, mon_e.ep, mon_e.bc, mon_e.ec);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; d_in = 4'b0000; d_sat = 4'b0000;
    repeat (3) step(4'b0000);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    check("rst_count_out", {29'd0, count_out}, 32'd0);
    check("rst_pulses", {28'd0, count_valid, frame_done, err_pulse, bad_code}, 32'd0);
    rst = 1'b1;

    // Clean lock: locked rises two edges after the second 1000.
    quiet_frame();
    quiet_frame();
    check("lock_early", {31'd0, locked}, 32'd0);
    lframe(8'd0);
    lframe(8'd0);

    // Single bad code while locked.
    sym(4'b0000, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    sym(4'b0001, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0);
    sym(4'b0010, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0);
    sym(4'b0110, 1'b0, 3'd2, 1'b0, 1'b1, 1'b1, 8'd1);
    sym(4'b1000, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 8'd1);
    check("bad_keeps_lock", {31'd0, locked}, 32'd1);
    lframe(8'd1);

    // Flywheel through two non-adjacent errors.
    sym(4'b0000, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'd1);
    sym(4'b1111, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'd2);
    sym(4'b0010, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'd2);
    sym(4'b1111, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 8'd3);
    sym(4'b1000, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 8'd3);
    check("flywheel_lock", {31'd0, locked}, 32'd1);
    lframe(8'd3);

    // Loss of lock after three consecutive errors.
    sym(4'b1111, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 8'd4);
    sym(4'b1111, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 8'd5);
    sym(4'b1111, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 8'd6);
    check("lock_before_third", {31'd0, locked}, 32'd1);
    step(4'b0000);
    check("lock_lost", {31'd0, locked}, 32'd0);
    check("err_after_loss", {24'd0, err_count}, 32'd6);
    step(4'b0001); step(4'b0010); step(4'b0100); step(4'b1000);
    quiet_frame();
    check("relock_early", {31'd0, locked}, 32'd0);
    lframe(8'd6);
    step(4'b0000);

    // Reset mid-lock.
    rst = 1'b0;
    step(4'b0000);
    rst = 1'b1;
    check("mid_rst_locked", {31'd0, locked}, 32'd0);
    check("mid_rst_err_count", {24'd0, err_count}, 32'd0);
    check("mid_rst_count_out", {29'd0, count_out}, 32'd0);
    check("mid_rst_pulses", {28'd0, count_valid, frame_done, err_pulse, bad_code}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      step(4'b0000);
      check("zeros_never_lock", {31'd0, locked}, 32'd0);
    end
    sym(4'b0110, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'd0);
    step(4'b0000);
    step(4'b0000);
    check("bad_outside_lock", {31'd0, locked}, 32'd0);

    // Saturation on the narrow-counter instance.
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 5; i++) step_sat(code_of(i));
    for (int k = 1; k <= 5; k++) begin
      step_sat(4'b0000);
      step_sat(4'b0001);
      step_sat(4'b1111);
      step_sat(4'b0100);
      step_sat(4'b1000);
      check("sat_err_count", {30'd0, sat_err_count}, (k < 3) ? k : 3);
      check("sat_locked", {31'd0, sat_locked}, 32'd1);
    end

    repeat (3) step(4'b0000);
    check("main_still_unlocked", {31'd0, locked}, 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
